ids_temp_seq: RTL and testbench
===============================

IDS_TEMP_SEQ -- requirements
Module: ids_temp_seq

Interface
REQ-001 SHALL have parameter SINGLE, default 32, float word width.
REQ-002 SHALL have parameter N_CH, default 8, number of panel channels per frame (2..64).
REQ-003 SHALL have parameter T_MIN, default 32'h43888000 (273.0), lower table bound.
REQ-004 SHALL have parameter T_MAX, default 32'h43C78000 (399.0), upper table bound.
REQ-005 SHALL have ports: clk input 1, sole clock. rst input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: sta input 1, frame start pulse. busy output 1, frame in progress.
REQ-007 SHALL have ports: t_rd output 1, temperature read strobe. t_addr output clog2(N_CH), channel index. t_data input SINGLE, temperature valid one cycle after t_rd.
REQ-008 SHALL have ports: ids_sta output 1, start to Ids interpolation stage. T_out output SINGLE, temperature to that stage. ids_done input 1, result strobe. ids_in input SINGLE, result.
REQ-009 SHALL have ports: wr_en output 1, wr_addr output clog2(N_CH), wr_data output SINGLE, result write port. oor output N_CH, per-channel out-of-range flags. done_sig output 1, frame complete pulse.

Function
REQ-010 SHALL implement states IDLE, FETCH, DRAIN, DONE. IDLE->FETCH on sta. FETCH->DRAIN after channel N_CH-1 is read. DRAIN->DONE when N_CH results are written. DONE->IDLE after one cycle.
REQ-011 SHALL, in FETCH, assert t_rd for N_CH consecutive cycles with t_addr = 0..N_CH-1.
REQ-012 SHALL register t_data, after range processing, into T_out and pulse ids_sta one cycle after each t_rd, giving back-to-back issue.
REQ-013 SHALL treat a word as below range if sign bit = 1 or unsigned word < T_MIN, and above range if unsigned word > T_MAX. The comparison is an unsigned integer compare of the positive IEEE-754 bit pattern.
REQ-014 SHALL set oor[ch] for an out-of-range channel. oor is cleared on each accepted sta.
REQ-015 SHALL count ids_done pulses in a return counter. Results return in issue order at a fixed 31-cycle downstream latency.
REQ-016 SHALL register each result: wr_en=1, wr_addr=return count, wr_data=ids_in, one cycle after ids_done.
REQ-017 SHALL pulse done_sig for one cycle, one cycle after the N_CH-th write. With sta at cycle 0, done_sig SHALL occur at cycle N_CH+34 (42 for N_CH=8).
REQ-018 SHALL hold busy=1 from the cycle after an accepted sta through the done_sig cycle.
REQ-019 SHALL ignore sta while busy=1.
REQ-020 SHALL ignore ids_done in IDLE and DONE. In DRAIN, an ids_done beyond N_CH SHALL be discarded.
REQ-021 SHALL make a write on the same cycle as a new issue without interference. Issue and return counters are independent.

Reset
REQ-022 SHALL force on rst low, asynchronously: state=IDLE, all counters 0, and t_rd, ids_sta, wr_en, done_sig, busy = 0.
REQ-023 SHALL force on rst low, asynchronously: T_out, wr_data, wr_addr, t_addr, oor = 0.
REQ-024 SHALL abandon a frame in progress on reset mid-frame. Results in flight SHALL be discarded after release because the state is IDLE.

Configuration
REQ-025 With IDS_TEMP_SEQ_CLAMP_EN defined: out-of-range values SHALL be replaced by T_MIN (below) or T_MAX (above) on T_out.
REQ-026 Without IDS_TEMP_SEQ_CLAMP_EN: T_out SHALL equal t_data unmodified. oor flagging SHALL be unchanged.

Structure
REQ-027 SHALL place the T_MIN/T_MAX constants, the state enum typedef and the float sign/compare helper in the shared PV package.
REQ-028 SHALL implement range check plus clamp as one sub-module, ids_temp_clamp, which is combinational and feeds the T_out register.

Verification
REQ-029 Bench: sta, all channels 300.0 (0x43960000), model downstream with 31-cycle delay -> T_out=0x43960000 ×8, oor=0, 8 writes addr 0..7, done_sig at cycle 42.
REQ-030 Bench: ch2=250.0 (0x437A0000), ch5=450.0 (0x43E10000), CLAMP_EN on -> T_out ch2=0x43888000, ch5=0x43C78000, oor=8'h24. With CLAMP_EN off -> raw values pass, oor=8'h24.
REQ-031 Bench: ch0=-5.0 (0xC0A00000), ch7 exactly 399.0 -> ch0 clamped to 0x43888000 with oor[0]=1. ch7 passes with oor[7]=0.
REQ-032 Bench: second sta at cycle 5 and at cycle 20 of a frame -> ignored, single done_sig at 42, busy continuous.
REQ-033 Bench: rst low at cycle 20 for 2 cycles -> all outputs 0 immediately. Stale ids_done after release produces no wr_en. A new sta completes normally.
REQ-034 Bench: spurious ids_done in IDLE -> no wr_en, return counter remains 0.

Source files
------------

// File: rtl/ids_temp_seq_pkg.sv
// Shared definitions for the Ids temperature sequencer: table bounds, state
// encoding and the float sign/magnitude range helpers.
package ids_temp_seq_pkg;

    localparam int FW = 32;

    localparam logic [FW-1:0] T_MIN_DEF = 32'h43888000;  // 273.0
    localparam logic [FW-1:0] T_MAX_DEF = 32'h43C78000;  // 399.0

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Positive IEEE-754 words order the same as their unsigned bit patterns,
    // so a plain integer compare works once negative values are split off.
    function automatic logic f_below(input logic [FW-1:0] w, input logic [FW-1:0] lo);
        return w[FW-1] || (w < lo);
    endfunction

    function automatic logic f_above(input logic [FW-1:0] w, input logic [FW-1:0] hi);
        return !w[FW-1] && (w > hi);
    endfunction

endpackage

// File: rtl/ids_temp_clamp.sv
// Combinational range check of one temperature word. With IDS_TEMP_SEQ_CLAMP_EN
// defined, out-of-range words are replaced by the nearest table bound.
module ids_temp_clamp
    import ids_temp_seq_pkg::*;
#(
    parameter int               SINGLE = 32,
    parameter logic [SINGLE-1:0] T_MIN = T_MIN_DEF,
    parameter logic [SINGLE-1:0] T_MAX = T_MAX_DEF
) (
    input  logic [SINGLE-1:0] din,
    output logic [SINGLE-1:0] dout,
    output logic              oor
);

    logic below;
    logic above;

    always_comb begin
        below = f_below(din, T_MIN);
        above = f_above(din, T_MAX);
        oor   = below | above;
`ifdef IDS_TEMP_SEQ_CLAMP_EN
        dout  = below ? T_MIN : (above ? T_MAX : din);
`else
        dout  = din;
`endif
    end

endmodule

// File: rtl/ids_temp_seq.sv
// Per-frame temperature fetch / Ids issue / result write-back sequencer.
// Optional clamping of out-of-range temperatures: define IDS_TEMP_SEQ_CLAMP_EN.
module ids_temp_seq
    import ids_temp_seq_pkg::*;
#(
    parameter int                SINGLE = 32,
    parameter int                N_CH   = 8,
    parameter logic [SINGLE-1:0] T_MIN  = T_MIN_DEF,
    parameter logic [SINGLE-1:0] T_MAX  = T_MAX_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sta,
    output logic                     busy,
    output logic                     t_rd,
    output logic [$clog2(N_CH)-1:0]  t_addr,
    input  logic [SINGLE-1:0]        t_data,
    output logic                     ids_sta,
    output logic [SINGLE-1:0]        T_out,
    input  logic                     ids_done,
    input  logic [SINGLE-1:0]        ids_in,
    output logic                     wr_en,
    output logic [$clog2(N_CH)-1:0]  wr_addr,
    output logic [SINGLE-1:0]        wr_data,
    output logic [N_CH-1:0]          oor,
    output logic                     done_sig
);

    localparam int AW = $clog2(N_CH);
    localparam int CW = AW + 1;

    state_t            state_q, state_d;
    logic [AW-1:0]     t_addr_q, t_addr_d;
    logic              rd_vld_q, rd_vld_d;
    logic [AW-1:0]     rd_addr_q, rd_addr_d;
    logic [SINGLE-1:0] t_out_q, t_out_d;
    logic              ids_sta_q, ids_sta_d;
    logic [N_CH-1:0]   oor_q, oor_d;
    logic [CW-1:0]     ret_q, ret_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [SINGLE-1:0] wr_data_q, wr_data_d;

    logic [SINGLE-1:0] clamp_dout;
    logic              clamp_oor;
    logic              sta_acc;
    logic              ret_acc;

    ids_temp_clamp #(
        .SINGLE (SINGLE),
        .T_MIN  (T_MIN),
        .T_MAX  (T_MAX)
    ) u_clamp (
        .din  (t_data),
        .dout (clamp_dout),
        .oor  (clamp_oor)
    );

    always_comb begin
        state_d   = state_q;
        t_addr_d  = t_addr_q;
        ret_d     = ret_q;
        oor_d     = oor_q;
        t_out_d   = t_out_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        sta_acc = (state_q == IDLE) && sta;
        // Results are only accepted while a frame is live and still owes writes.
        ret_acc = ids_done && ((state_q == FETCH) || (state_q == DRAIN)) && (ret_q < CW'(N_CH));

        case (state_q)
            IDLE:  if (sta) state_d = FETCH;
            FETCH: begin
                if (t_addr_q == AW'(N_CH - 1)) begin
                    t_addr_d = '0;
                    state_d  = DRAIN;
                end else begin
                    t_addr_d = t_addr_q + 1'b1;
                end
            end
            DRAIN: if (ret_q == CW'(N_CH)) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Issue path: the word read in the previous cycle arrives now.
        rd_vld_d  = (state_q == FETCH);
        rd_addr_d = t_addr_q;
        ids_sta_d = rd_vld_q;
        if (rd_vld_q) begin
            t_out_d = clamp_dout;
            if (clamp_oor) oor_d[rd_addr_q] = 1'b1;
        end
        if (sta_acc) begin
            oor_d = '0;
            ret_d = '0;
        end else if (ret_acc) begin
            ret_d = ret_q + 1'b1;
        end

        // Return path, independent of the issue path.
        wr_en_d = ret_acc;
        if (ret_acc) begin
            wr_addr_d = ret_q[AW-1:0];
            wr_data_d = ids_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            t_addr_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            t_out_q   <= '0;
            ids_sta_q <= 1'b0;
            oor_q     <= '0;
            ret_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            t_addr_q  <= t_addr_d;
            rd_vld_q  <= rd_vld_d;
            rd_addr_q <= rd_addr_d;
            t_out_q   <= t_out_d;
            ids_sta_q <= ids_sta_d;
            oor_q     <= oor_d;
            ret_q     <= ret_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign t_rd     = (state_q == FETCH);
    assign done_sig = (state_q == DONE);
    assign t_addr   = t_addr_q;
    assign ids_sta  = ids_sta_q;
    assign T_out    = t_out_q;
    assign oor      = oor_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_ids_temp_seq.sv
// Self-checking bench for ids_temp_seq: temperature memory and a 31-cycle
// downstream Ids stage are modelled here; expectations come from the range rules.
module tb_ids_temp_seq;

    localparam int N = 8;
    localparam logic [31:0] TMIN = 32'h43888000;
    localparam logic [31:0] TMAX = 32'h43C78000;
`ifdef IDS_TEMP_SEQ_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sta = 1'b0;
    logic        busy, t_rd, ids_sta, wr_en, done_sig;
    logic [2:0]  t_addr, wr_addr;
    logic [31:0] t_data, T_out, ids_in, wr_data;
    logic        ids_done;
    logic [N-1:0] oor;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] temps [N];
    logic        manual_done = 1'b0;
    longint      tick = 0;
    int          stale_seen = 0;

    ids_temp_seq #(.SINGLE(32), .N_CH(N), .T_MIN(TMIN), .T_MAX(TMAX)) dut (
        .clk(clk), .rst(rst), .sta(sta), .busy(busy),
        .t_rd(t_rd), .t_addr(t_addr), .t_data(t_data),
        .ids_sta(ids_sta), .T_out(T_out), .ids_done(ids_done), .ids_in(ids_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .oor(oor), .done_sig(done_sig)
    );

    always #5 clk = ~clk;

    // Downstream Ids stage: deterministic transform of the issued temperature.
    function automatic logic [31:0] ds_fn(input logic [31:0] t);
        return {t[15:0], t[31:16]} ^ 32'h13579BDF;
    endfunction

    function automatic bit model_oor(input logic [31:0] w);
        return w[31] || (w < TMIN) || (!w[31] && (w > TMAX));
    endfunction

    function automatic logic [31:0] model_t(input logic [31:0] w);
        if (!CLAMP) return w;
        if (w[31] || w < TMIN) return TMIN;
        if (w > TMAX) return TMAX;
        return w;
    endfunction

    function automatic logic [31:0] rand_temp();
        case ($urandom_range(0, 4))
            0: return TMIN + $urandom_range(0, TMAX - TMIN);
            1: return $urandom_range(0, TMIN - 1);
            2: return TMAX + 1 + $urandom_range(0, 32'h3000_0000);
            3: return {1'b1, 31'($urandom())};
            default: return ($urandom_range(0, 1) != 0) ? TMIN : TMAX;
        endcase
    endfunction

    // Temperature memory (one-cycle read) and the delayed result return.
    initial begin : ds_model
        logic        rd_s, is_s;
        logic [2:0]  ad_s;
        logic [31:0] tv_s;
        longint      due_q [$];
        logic [31:0] dat_q [$];
        t_data = '0; ids_done = 1'b0; ids_in = '0;
        forever begin
            @(negedge clk);
            rd_s = t_rd; ad_s = t_addr; is_s = ids_sta; tv_s = T_out;
            @(posedge clk);
            tick++;
            #1;
            t_data = rd_s ? temps[ad_s] : $urandom();
            if (is_s) begin
                due_q.push_back(tick + 30);
                dat_q.push_back(ds_fn(tv_s));
            end
            ids_done = manual_done;
            ids_in   = $urandom();
            if (due_q.size() > 0 && due_q[0] == tick) begin
                ids_done = 1'b1;
                ids_in   = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end
        end
    end

    task automatic run_frame(input string nm, input int s2a, input int s2b);
        logic [31:0] et [N];
        logic [N-1:0] eo;
        logic [31:0] got_t [$];
        int          wa [$];
        logic [31:0] wd [$];
        int busy_bad = 0, rd_bad = 0, iss_bad = 0, wr_tm_bad = 0, n_done = 0, done_at = -1;
        eo = '0;
        for (int i = 0; i < N; i++) begin
            et[i] = model_t(temps[i]);
            eo[i] = model_oor(temps[i]);
        end
        @(posedge clk); #1 sta = 1'b1;
        @(posedge clk); #1 sta = 1'b0;
        for (int c = 0; c <= 50; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            sta = (c == s2a) || (c == s2b);
            if (busy !== (c <= 42)) busy_bad++;
            if (t_rd !== (c <= N - 1) || (c <= N - 1 && t_addr !== 3'(c))) rd_bad++;
            if (ids_sta === 1'b1) begin
                if (c != 2 + got_t.size()) iss_bad++;
                got_t.push_back(T_out);
            end
            if (wr_en === 1'b1) begin
                if (c != 34 + wa.size()) wr_tm_bad++;
                wa.push_back(int'(wr_addr));
                wd.push_back(wr_data);
            end
            if (done_sig === 1'b1) begin n_done++; done_at = c; end
        end
        sta = 1'b0;
        n_cmp++; if (busy_bad != 0) begin n_fail++; $display("FAIL %s busy: %0d bad cycles, required 0", nm, busy_bad); end
        n_cmp++; if (rd_bad != 0) begin n_fail++; $display("FAIL %s t_rd/t_addr: %0d bad cycles, required 0", nm, rd_bad); end
        n_cmp++; if (got_t.size() != N || iss_bad != 0) begin n_fail++; $display("FAIL %s issue: got %0d issues (%0d mistimed), required %0d at cycles 2..%0d", nm, got_t.size(), iss_bad, N, N + 1); end
        for (int k = 0; k < N && k < got_t.size(); k++) begin
            n_cmp++; if (got_t[k] !== et[k]) begin n_fail++; $display("FAIL %s T_out[%0d]: got %h required %h", nm, k, got_t[k], et[k]); end
        end
        n_cmp++; if (oor !== eo) begin n_fail++; $display("FAIL %s oor: got %h required %h", nm, oor, eo); end
        n_cmp++; if (wa.size() != N || wr_tm_bad != 0) begin n_fail++; $display("FAIL %s writes: got %0d (%0d mistimed), required %0d at cycles 34..41", nm, wa.size(), wr_tm_bad, N); end
        for (int k = 0; k < N && k < wa.size(); k++) begin
            n_cmp++; if (wa[k] != k || wd[k] !== ds_fn(et[k])) begin n_fail++; $display("FAIL %s write[%0d]: got addr %0d data %h required addr %0d data %h", nm, k, wa[k], wd[k], k, ds_fn(et[k])); end
        end
        n_cmp++; if (n_done != 1 || done_at != 42) begin n_fail++; $display("FAIL %s done_sig: got %0d pulses last at %0d, required 1 at 42", nm, n_done, done_at); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({busy, t_rd, ids_sta, wr_en, done_sig} !== 5'b0) begin n_fail++; $display("FAIL reset ctrl: got %b required 00000", {busy, t_rd, ids_sta, wr_en, done_sig}); end
        n_cmp++; if ({t_addr, wr_addr} !== 6'b0) begin n_fail++; $display("FAIL reset addr: got %h required 0", {t_addr, wr_addr}); end
        n_cmp++; if (T_out !== 32'h0 || wr_data !== 32'h0) begin n_fail++; $display("FAIL reset data: got %h/%h required 0/0", T_out, wr_data); end
        n_cmp++; if (oor !== '0) begin n_fail++; $display("FAIL reset oor: got %h required 00", oor); end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || t_rd !== 1'b0) begin n_fail++; $display("FAIL reset release idle: got busy %b t_rd %b required 0 0", busy, t_rd); end
    endtask

    task automatic test_nominal();
        for (int i = 0; i < N; i++) temps[i] = 32'h43960000;
        run_frame("nominal", -1, -1);
    endtask

    task automatic test_range();
        for (int i = 0; i < N; i++) temps[i] = TMIN + $urandom_range(0, TMAX - TMIN);
        temps[2] = 32'h437A0000;
        temps[5] = 32'h43E10000;
        run_frame("range", -1, -1);
    endtask

    task automatic test_boundary();
        for (int i = 0; i < N; i++) temps[i] = TMIN + $urandom_range(0, TMAX - TMIN);
        temps[0] = 32'hC0A00000;
        temps[1] = TMIN;
        temps[7] = TMAX;
        run_frame("boundary", -1, -1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < N; i++) temps[i] = rand_temp();
            run_frame("random", -1, -1);
        end
    endtask

    task automatic test_ignored_sta();
        for (int i = 0; i < N; i++) temps[i] = rand_temp();
        run_frame("ignored_sta", 5, 20);
    endtask

    task automatic test_spurious_done();
        int wr_seen = 0;
        manual_done = 1'b1;
        repeat (4) @(posedge clk);
        manual_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (wr_en === 1'b1) wr_seen++;
        end
        n_cmp++; if (wr_seen != 0) begin n_fail++; $display("FAIL spurious wr_en: got %0d writes required 0", wr_seen); end
        for (int i = 0; i < N; i++) temps[i] = rand_temp();
        run_frame("after_spurious", -1, -1);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        for (int i = 0; i < N; i++) temps[i] = 32'h43960000;
        temps[3] = 32'h43E10000;
        @(posedge clk); #1 sta = 1'b1;
        @(posedge clk); #1 sta = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        n_cmp++; if ({busy, t_rd, ids_sta, wr_en, done_sig} !== 5'b0 || T_out !== 32'h0 || wr_data !== 32'h0 || oor !== '0 || t_addr !== 3'h0 || wr_addr !== 3'h0) begin
            n_fail++; $display("FAIL midreset outputs: got ctrl %b T_out %h wr_data %h oor %h required all 0", {busy, t_rd, ids_sta, wr_en, done_sig}, T_out, wr_data, oor);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        stale_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ids_done === 1'b1) stale_seen++;
            if (wr_en !== 1'b0 || done_sig !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL midreset stale: got %0d active cycles (stale ids_done %0d) required 0", bad, stale_seen); end
        for (int i = 0; i < N; i++) temps[i] = rand_temp();
        run_frame("after_midreset", -1, -1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) temps[i] = '0;
        test_reset();
        test_nominal();
        test_range();
        test_boundary();
        test_random();
        test_ignored_sta();
        test_spurious_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

endmodule
